// File: rtl/dmem_access_ctrl_if.sv
// CPU load/store and data-RAM signal bundle for the data-memory access controller.
// The slave view belongs to the controller; the master view belongs to the CPU datapath
// and the RAM that sit around it.
interface dmem_access_ctrl_if;
  // CPU request side
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  // CPU response side
  logic [31:0] rdata;
  logic        ready;
  logic        misalign;
  logic        out_of_range;
  // RAM side
  logic [31:0] ram_addr;
  logic [31:0] ram_datain;
  logic        ram_we;
  logic [31:0] ram_dataout;

  modport slave (
    input  req, wr, size, sign_ext, addr, wdata, ram_dataout,
    output rdata, ready, misalign, out_of_range, ram_addr, ram_datain, ram_we
  );

  modport master (
    output req, wr, size, sign_ext, addr, wdata, ram_dataout,
    input  rdata, ready, misalign, out_of_range, ram_addr, ram_datain, ram_we
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Multicycle data-memory access controller: turns byte/halfword/word loads and stores
// into accesses of a word-addressed RAM with asynchronous read. Sub-word stores are done
// as read-modify-write, and misaligned or out-of-range accesses complete without
// touching the RAM.
module dmem_access_ctrl #(
  parameter int DEPTH_LOG2 = 5
) (
  input logic               clock,
  input logic               resetn,
  dmem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] datain_q;     // latched store data, later replaced by the merged word
  logic [1:0]  size_q;
  logic        sext_q;
  logic        wr_q;
  logic [31:0] rdata_q;
  logic        misalign_q;
  logic        oor_q;

  logic        accept;
  logic        chk_mis;
  logic        chk_oor;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  // Select the addressed lane of a little-endian word and zero/sign-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lo,
                                               input logic [1:0] sz, input logic sext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bs;
    logic signed [31:0] hs;
    b  = word[{lo, 3'b000} +: 8];
    h  = word[{lo[1], 4'b0000} +: 16];
    bs = b;
    hs = h;
    case (sz)
      2'b00:   return sext ? bs : {24'b0, b};
      2'b01:   return sext ? hs : {16'b0, h};
      default: return word;
    endcase
  endfunction

  // Replace the addressed lane of the current RAM word with the low store-data bits.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [1:0] sz, input logic [15:0] wd);
    logic [31:0] m;
    m = word;
    case (sz)
      2'b00:   m[{lo, 3'b000} +: 8]     = wd[7:0];
      2'b01:   m[{lo[1], 4'b0000} +: 16] = wd;
      default: m = word;
    endcase
    return m;
  endfunction

  assign accept  = (state_q == IDLE) && bus.req;
  assign chk_mis = is_misaligned(bus.size, bus.addr[1:0]);
  assign chk_oor = |bus.addr[31:DEPTH_LOG2+2];

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode; misalignment outranks the range check.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (chk_mis || chk_oor) state_d = ERR;
          else if (!bus.wr)       state_d = RD;
          else if (bus.size[1])   state_d = WR;
          else                    state_d = RD;
        end
      end
      RD:      state_d = wr_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so reset drops them at once.
  always_comb begin
    bus.ram_we = 1'b0;
    bus.ready  = 1'b0;
    case (state_q)
      WR:      bus.ram_we = 1'b1;
      RESP:    bus.ready  = 1'b1;
      ERR:     bus.ready  = 1'b1;
      default: ;
    endcase
  end

  // Request latch at accept; RAM word captured at the end of RD for loads or merges.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      datain_q   <= '0;
      size_q     <= '0;
      sext_q     <= 1'b0;
      wr_q       <= 1'b0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      oor_q      <= 1'b0;
    end else if (accept) begin
      addr_q     <= bus.addr;
      datain_q   <= bus.wdata;
      size_q     <= bus.size;
      sext_q     <= bus.sign_ext;
      wr_q       <= bus.wr;
      misalign_q <= chk_mis;
      oor_q      <= !chk_mis && chk_oor;
    end else if (state_q == RD) begin
      if (wr_q) datain_q <= store_merge(bus.ram_dataout, addr_q[1:0], size_q, datain_q[15:0]);
      else      rdata_q  <= load_extract(bus.ram_dataout, addr_q[1:0], size_q, sext_q);
    end
  end

  assign bus.ram_addr     = addr_q;
  assign bus.ram_datain   = datain_q;
  assign bus.rdata        = rdata_q;
  assign bus.misalign     = misalign_q;
  assign bus.out_of_range = oor_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 32-word asynchronous-read RAM model.
module tb_dmem_access_ctrl;
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  dmem_access_ctrl_if bus();

  dmem_access_ctrl #(.DEPTH_LOG2(5)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // RAM model: asynchronous read, write on the rising edge, plus a preload port.
  logic [31:0] mem [0:31];
  logic        pre_en = 1'b0;
  logic [4:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  always @(posedge clock) begin
    if (pre_en)          mem[pre_idx] <= pre_val;
    else if (bus.ram_we) mem[bus.ram_addr[6:2]] <= bus.ram_datain;
  end
  assign bus.ram_dataout = mem[bus.ram_addr[6:2]];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clock);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  // One transaction issued from an IDLE cycle. Request fields are scrambled (req held)
  // after the accept edge to show they are ignored. Returns the cycle of the ready pulse,
  // the number and cycle of RAM write pulses, and the write data seen.
  task automatic xact(input logic w, input logic [1:0] sz, input logic se,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int rdy_cyc, output int we_cnt, output int we_cyc,
                      output logic [31:0] we_dat);
    rdy_cyc = -1; we_cnt = 0; we_cyc = -1; we_dat = '0;
    @(posedge clock); @(negedge clock);
    bus.req = 1'b1; bus.wr = w; bus.size = sz; bus.sign_ext = se; bus.addr = a; bus.wdata = wd;
    @(posedge clock); @(negedge clock);
    bus.wr = ~w; bus.size = ~sz; bus.sign_ext = ~se; bus.addr = a ^ 32'h0000_0046; bus.wdata = ~wd;
    for (int n = 1; n <= 8; n++) begin
      if (bus.ram_we) begin we_cnt++; we_cyc = n; we_dat = bus.ram_datain; end
      if (bus.ready) begin rdy_cyc = n; break; end
      @(posedge clock); @(negedge clock);
    end
    bus.req = 1'b0;
  endtask

  int          rc, wc, wcy;
  logic [31:0] wdat;
  logic [8:0]  mask;

  initial begin
    resetn = 1'b0;
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    preload(5'd14, 32'h0000_00A3);
    preload(5'd0,  32'hBF80_0000);
    preload(5'd15, 32'h0000_0027);
    preload(5'd16, 32'hDEAD_BEEF);
    preload(5'd4,  32'h1111_1111);

    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_ready", 32'(bus.ready), 32'h0);
    check("rst_flags", {30'b0, bus.misalign, bus.out_of_range}, 32'h0);
    check("rst_ram_addr", bus.ram_addr, 32'h0);
    check("rst_ram_datain", bus.ram_datain, 32'h0);
    check("rst_ram_we", 32'(bus.ram_we), 32'h0);
    resetn = 1'b1;

    xact(1'b0, 2'b00, 1'b1, 32'h38, 32'h0, rc, wc, wcy, wdat);
    check("lb_s_rdata", bus.rdata, 32'hFFFF_FFA3);
    check("lb_s_ready_cyc", rc, 32'd2);
    xact(1'b0, 2'b00, 1'b0, 32'h38, 32'h0, rc, wc, wcy, wdat);
    check("lb_u_rdata", bus.rdata, 32'h0000_00A3);
    check("lb_u_ready_cyc", rc, 32'd2);
    check("lb_u_we_cnt", wc, 32'd0);

    xact(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, rc, wc, wcy, wdat);
    check("lh_s_rdata", bus.rdata, 32'hFFFF_BF80);
    xact(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, rc, wc, wcy, wdat);
    check("lh_u_rdata", bus.rdata, 32'h0000_BF80);
    xact(1'b0, 2'b10, 1'b1, 32'h0, 32'h0, rc, wc, wcy, wdat);
    check("lw_rdata", bus.rdata, 32'hBF80_0000);
    check("lw_ready_cyc", rc, 32'd2);

    xact(1'b1, 2'b00, 1'b0, 32'h3D, 32'hAAAA_AA55, rc, wc, wcy, wdat);
    check("sb_we_cnt", wc, 32'd1);
    check("sb_we_cyc", wcy, 32'd2);
    check("sb_datain", wdat, 32'h0000_5527);
    check("sb_ready_cyc", rc, 32'd3);
    check("sb_mem15", mem[15], 32'h0000_5527);
    check("sb_rdata_kept", bus.rdata, 32'hBF80_0000);
    xact(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, rc, wc, wcy, wdat);
    check("lw_after_sb", bus.rdata, 32'h0000_5527);

    xact(1'b1, 2'b01, 1'b0, 32'h2, 32'h1234_CAFE, rc, wc, wcy, wdat);
    check("sh_datain", wdat, 32'hCAFE_0000);
    check("sh_we_cyc", wcy, 32'd2);
    check("sh_ready_cyc", rc, 32'd3);
    check("sh_mem0", mem[0], 32'hCAFE_0000);

    xact(1'b1, 2'b10, 1'b0, 32'h42, 32'h0BAD_0BAD, rc, wc, wcy, wdat);
    check("mis_flag", {30'b0, bus.misalign, bus.out_of_range}, 32'h2);
    check("mis_ready_cyc", rc, 32'd1);
    check("mis_we_cnt", wc, 32'd0);
    check("mis_mem16", mem[16], 32'hDEAD_BEEF);
    check("mis_rdata_kept", bus.rdata, 32'h0000_5527);

    xact(1'b0, 2'b01, 1'b1, 32'h80, 32'h0, rc, wc, wcy, wdat);
    check("oor_flag", {30'b0, bus.misalign, bus.out_of_range}, 32'h1);
    check("oor_ready_cyc", rc, 32'd1);
    check("oor_rdata_kept", bus.rdata, 32'h0000_5527);

    xact(1'b0, 2'b10, 1'b0, 32'h81, 32'h0, rc, wc, wcy, wdat);
    check("mis_over_oor", {30'b0, bus.misalign, bus.out_of_range}, 32'h2);

    xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rc, wc, wcy, wdat);
    check("flags_cleared", {30'b0, bus.misalign, bus.out_of_range}, 32'h0);
    check("lw0_rdata", bus.rdata, 32'hCAFE_0000);

    xact(1'b1, 2'b11, 1'b0, 32'h10, 32'h600D_F00D, rc, wc, wcy, wdat);
    check("sw_we_cyc", wcy, 32'd1);
    check("sw_ready_cyc", rc, 32'd2);
    check("sw_mem4", mem[4], 32'h600D_F00D);

    // Reset in the middle of a word store's WR cycle.
    @(posedge clock); @(negedge clock);
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'b10; bus.addr = 32'h10; bus.wdata = 32'hBAD0_BAD0;
    @(posedge clock); @(negedge clock);
    bus.req = 1'b0;
    check("wr_before_rst", 32'(bus.ram_we), 32'h1);
    #1 resetn = 1'b0;
    #1;
    check("rst_wr_we", 32'(bus.ram_we), 32'h0);
    check("rst_wr_rdata", bus.rdata, 32'h0);
    check("rst_wr_ram_addr", bus.ram_addr, 32'h0);
    check("rst_wr_ram_datain", bus.ram_datain, 32'h0);
    check("rst_wr_ready", 32'(bus.ready), 32'h0);
    @(posedge clock); @(negedge clock);
    check("rst_wr_ready_after", 32'(bus.ready), 32'h0);
    resetn = 1'b1;
    check("rst_wr_mem4", mem[4], 32'h600D_F00D);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rc, wc, wcy, wdat);
    check("post_rst_rdata", bus.rdata, 32'h600D_F00D);
    check("post_rst_ready_cyc", rc, 32'd2);

    // Back-to-back loads with req held high: one transaction per pass through IDLE.
    @(posedge clock); @(negedge clock);
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0; bus.addr = 32'h3C;
    mask = '0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clock); @(negedge clock);
      if (bus.ready) mask[n-1] = 1'b1;
    end
    bus.req = 1'b0;
    check("b2b_ready_mask", {23'b0, mask}, 32'h0000_0092);
    check("b2b_rdata", bus.rdata, 32'h0000_5527);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Multicycle data-memory access controller between the CPU load/store datapath and the 32-word data RAM. The RAM has asynchronous read, write-on-clock-edge, and word addressing via `addr[6:2]`. This block turns byte, halfword and word loads and stores into RAM word accesses. Sub-word stores are done as read-modify-write. Loads are extracted and zero- or sign-extended. Misaligned and out-of-range accesses are flagged without touching the RAM. The CPU sees a req/ready handshake and stalls until ready.

## Interface
Parameters:
- `DEPTH_LOG2`, default 5: RAM holds 2^DEPTH_LOG2 words. Word index is `addr[DEPTH_LOG2+1:2]`.

Ports:
- `clock`  in  1: rising-edge clock. Shared with the RAM.
- `resetn`  in  1: asynchronous, active-low reset.
- `req`  in  1: access request. Sampled only in IDLE.
- `wr`  in  1: 1 = store, 0 = load.
- `size`  in  2: 00 byte, 01 halfword, 10 word. 11 is treated as word.
- `sign_ext`  in  1: loads only. 1 = sign-extend, 0 = zero-extend.
- `addr`  in  32: byte address.
- `wdata`  in  32: store data, taken from the low bits.
- `rdata`  out  32: load result (registered).
- `ready`  out  1: one-cycle completion pulse.
- `misalign`  out  1: completed access was misaligned (registered).
- `out_of_range`  out  1: completed access was outside RAM (registered).
- `ram_addr`  out  32: address to the RAM.
- `ram_datain`  out  32: write data to the RAM.
- `ram_we`  out  1: RAM write enable.
- `ram_dataout`  in  32: RAM asynchronous read data.

## Operation
- State machine states: IDLE, RD, WR, RESP, ERR.
- IDLE with `req`=1 at a clock edge accepts the request:
  - `addr`, `wdata`, `size`, `sign_ext` and `wr` are latched.
  - `misalign` and `out_of_range` are cleared.
- Check priority at accept:
  - Misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0. Go to ERR with `misalign`=1.
  - Out of range: `addr[31:DEPTH_LOG2+2]`≠0. Go to ERR with `out_of_range`=1.
  - Misalignment is checked first.
- Otherwise:
  - Load goes to RD.
  - Word store goes to WR.
  - Byte or halfword store goes to RD.
- RD: on the edge ending RD, `ram_dataout` is captured into the word register.
  - Load: `rdata` is loaded with the extracted, extended value; go to RESP.
  - Sub-word store: the merge data is built; go to WR.
- Lanes are little-endian:
  - Byte k = bits [8k+7:8k], k = `addr[1:0]`.
  - Halfword = bits [16h+15:16h], h = `addr[1]`.
- Merge: the word register with the selected lane replaced by `wdata[7:0]` (byte) or `wdata[15:0]` (halfword). A word store uses `wdata` unmodified.
- WR: `ram_we`=1 for exactly this cycle, `ram_datain` = merge data. Then go to RESP.
- RESP: `ready`=1; go to IDLE.
- ERR: `ready`=1; no RAM write occurs; `rdata` is unchanged; go to IDLE.
- `ram_addr` is the latched address, valid in every state. `ram_we` is decoded from the state register and is never high outside WR.
- `req` is ignored outside IDLE. A new request may be accepted on the edge that ends RESP/ERR only if IDLE is entered first. There is therefore at least one IDLE cycle between transactions.
- `rdata` holds its value until the next completed load. Stores and errors do not modify it.
- Reset values (asynchronous, immediate):
  - State = IDLE.
  - `rdata` = 0, `ready` = 0, `misalign` = 0, `out_of_range` = 0.
  - `ram_addr` = 0, `ram_datain` = 0, `ram_we` = 0.
- Reset during WR drops `ram_we` at once; no partial write is required to be recorded. Reset during any state abandons the transaction with no `ready` pulse.

## Timing
Cycle numbering: the accept edge is E0; cycle n is the period after edge En-1.
- Load: RD in cycle 1, RESP in cycle 2. `ready` and valid `rdata` in cycle 2.
- Word store: WR in cycle 1 (RAM written at E1), `ready` in cycle 2.
- Sub-word store: RD in cycle 1, WR in cycle 2 (written at E2), `ready` in cycle 3.
- Error: ERR in cycle 1, `ready` together with the flag in cycle 1.
- `misalign` and `out_of_range` stay valid from the ready cycle until the next accept.

## Test plan
- Reset, then load word 14 (0x000000A3), byte at 0x38:
  - `sign_ext`=1 → `rdata`=0xFFFFFFA3.
  - `sign_ext`=0 → 0x000000A3.
  - `ready` in cycle 2 both times.
- Word 0 = 0xBF800000, halfword load at 0x2:
  - Signed → 0xFFFFBF80.
  - Unsigned → 0x0000BF80.
  - Word load at 0x0 → 0xBF800000.
- Byte store 0x55 to 0x3D (word 15 = 0x00000027) → single `ram_we` pulse in cycle 2, `ram_datain`=0x00005527, `ready` in cycle 3. A word read at 0x3C then returns 0x00005527.
- Word store to 0x42 → `misalign`=1 and `ready` in cycle 1, `ram_we` never asserted, RAM unchanged. Halfword load at 0x80 → `out_of_range`=1, `rdata` unchanged.
- Drop `resetn` during WR of a word store → `ram_we` and all outputs return to reset values immediately, no `ready`. The next request completes normally.
- Hold `req`=1 continuously for back-to-back loads → one transaction per pass through IDLE. `req` changes during RD/WR have no effect.
